// File: rtl/mire_writer_if.sv
// ----------------------------------------------------------------------------
// mire_writer_if
//   Wishbone bus bundle between the test-pattern writer (master) and the
//   SDRAM-side arbiter (slave).
//   Signals:
//     cyc, stb, we   bus cycle, strobe, write enable        (master -> slave)
//     adr            32-bit byte address                   (master -> slave)
//     dat_ms         32-bit write data {8'h00,R,G,B}        (master -> slave)
//     sel, cti, bte  byte select / cycle type / burst type  (master -> slave)
//     ack            slave acknowledge                     (slave -> master)
// ----------------------------------------------------------------------------
interface mire_writer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_writer.sv
// ----------------------------------------------------------------------------
// mire_writer
//   Wishbone master that fills the SDRAM framebuffer with a scrolling grid
//   test pattern. One 32-bit word {8'h00,R,G,B} per pixel at byte address
//   4*(HDISP*Y+X). The bus is released every BURST words (and at the end of
//   each frame) for PAUSE_CYCLES cycles so the arbiter can serve the VGA
//   reader.
//   Ports:
//     clk         Wishbone clock
//     rst_n       synchronous reset, active low
//     enable      1 = keep writing frames, 0 = stop after the current word
//     wshb        Wishbone master port (see mire_writer_if)
//     frame_done  one-cycle pulse after the last pixel of a frame is acked
//     frame_cnt   completed-frame counter, wraps 15 -> 0
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | bus released, waiting for enable; X/Y keep their position
//   WRITE | cyc=stb=1, current pixel word held until ack
//   PAUSE | bus released for PAUSE_CYCLES cycles between tenures
// ----------------------------------------------------------------------------
module mire_writer #(
  parameter int HDISP        = 800,
  parameter int VDISP        = 480,
  parameter int BURST        = 64,
  parameter int PAUSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  mire_writer_if.master    wshb,
  output logic             frame_done,
  output logic [3:0]       frame_cnt
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int PW = $clog2(PAUSE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [PW-1:0] pause_cnt, pause_nxt;
  logic [3:0]    fcnt_nxt;
  logic          fdone_nxt;
  logic [31:0]   adr_q, dat_q;

  logic          ack_ok;
  logic          last_x, last_y, last_b;
  logic [31:0]   lin_nxt;
  logic [3:0]    xs_nxt;
  logic          white_nxt;

  // An ack only counts while we are actually strobing.
  assign ack_ok = (state == WRITE) && wshb.ack;
  assign last_x = (x == XW'(HDISP - 1));
  assign last_y = (y == YW'(VDISP - 1));
  assign last_b = (burst_cnt == BW'(BURST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      burst_cnt  <= '0;
      pause_cnt  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      burst_cnt  <= burst_nxt;
      pause_cnt  <= pause_nxt;
      frame_cnt  <= fcnt_nxt;
      frame_done <= fdone_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    burst_nxt = burst_cnt;
    pause_nxt = pause_cnt;
    fcnt_nxt  = frame_cnt;
    fdone_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (enable) state_nxt = WRITE;
      end

      WRITE: begin
        if (ack_ok) begin
          if (last_x) begin
            x_nxt = '0;
            y_nxt = last_y ? '0 : y + YW'(1);
          end else begin
            x_nxt = x + XW'(1);
          end

          if (last_x && last_y) begin
            fcnt_nxt  = frame_cnt + 4'd1;
            fdone_nxt = 1'b1;
            burst_nxt = '0;
            state_nxt = PAUSE;
          end else if (last_b) begin
            burst_nxt = '0;
            state_nxt = PAUSE;
          end else begin
            burst_nxt = burst_cnt + BW'(1);
          end

          // Stopping wins over pausing; the next enable starts a fresh tenure.
          if (!enable) begin
            burst_nxt = '0;
            state_nxt = IDLE;
          end

          // Down-count so PAUSE lasts exactly PAUSE_CYCLES cycles.
          if (state_nxt == PAUSE) pause_nxt = PW'(PAUSE_CYCLES - 1);
        end
      end

      PAUSE: begin
        if (pause_cnt == '0) begin
          state_nxt = enable ? WRITE : IDLE;
        end else begin
          pause_nxt = pause_cnt - PW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Address and pattern are built from the next-state position so that the
  // new word is on the bus the cycle right after the ack.
  assign lin_nxt   = 32'(HDISP) * 32'(y_nxt) + 32'(x_nxt);
  assign xs_nxt    = 4'(x_nxt) + fcnt_nxt;
  assign white_nxt = (xs_nxt == 4'd0) || (4'(y_nxt) == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adr_q <= '0;
      dat_q <= '0;
    end else if (state_nxt == WRITE) begin
      adr_q <= lin_nxt << 2;
      dat_q <= white_nxt ? 32'h00FF_FFFF : 32'h0000_00FF;
    end
  end

  assign wshb.cyc    = (state == WRITE);
  assign wshb.stb    = (state == WRITE);
  assign wshb.we     = 1'b1;
  assign wshb.adr    = adr_q;
  assign wshb.dat_ms = dat_q;
  assign wshb.sel    = 4'b1111;
  assign wshb.cti    = 3'b000;
  assign wshb.bte    = 2'b00;

endmodule

// File: tb/tb_mire_writer.sv
module tb_mire_writer;

  localparam int HDISP        = 20;
  localparam int VDISP        = 18;
  localparam int BURST        = 8;
  localparam int PAUSE_CYCLES = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       frame_done;
  logic [3:0] frame_cnt;

  mire_writer_if wb();

  mire_writer #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .PAUSE_CYCLES(PAUSE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wshb(wb),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pixel position, frame count, words in current tenure.
  int mx, my, mf, mwords, total;

  function automatic logic [31:0] m_adr();
    return 32'(4 * (HDISP * my + mx));
  endfunction

  function automatic logic [31:0] m_dat();
    if (((mx + mf) % 16 == 0) || (my % 16 == 0)) return 32'h00FF_FFFF;
    return 32'h0000_00FF;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mf = 0; mwords = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Acts as the slave for one word: waits for the strobe, checks the word,
  // acks dly cycles later, then checks frame/pause behaviour from the model.
  task automatic serve(input int dly, input bit drop_en);
    int n;
    bit fend, tend;
    n = 0;
    while (wb.stb !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stb_seen", 32'(wb.stb), 32'd1);
    chk("cyc", 32'(wb.cyc), 32'd1);
    chk("adr", wb.adr, m_adr());
    chk("dat", wb.dat_ms, m_dat());
    chk("frame_done_low", 32'(frame_done), 32'd0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("adr_hold", wb.adr, m_adr());
    end
    wb.ack = 1'b1;
    @(negedge clk);
    wb.ack = 1'b0;

    fend = 1'b0;
    mx++;
    if (mx == HDISP) begin
      mx = 0;
      my++;
      if (my == VDISP) begin
        my = 0;
        mf = (mf + 1) % 16;
        fend = 1'b1;
      end
    end
    mwords++;
    total++;
    tend = fend || (mwords == BURST);
    chk("frame_done", 32'(frame_done), 32'(fend));
    chk("frame_cnt", 32'(frame_cnt), 32'(mf));

    if (drop_en) begin
      mwords = 0;
      wb.ack = 1'b1;                     // stray ack while idle must be ignored
      for (int i = 0; i < 6; i++) begin
        chk("idle_cyc", 32'(wb.cyc), 32'd0);
        @(negedge clk);
        wb.ack = 1'b0;
      end
    end else if (tend) begin
      mwords = 0;
      n = 0;
      wb.ack = 1'b1;                     // stray ack during pause must be ignored
      while (wb.cyc !== 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
        wb.ack = 1'b0;
      end
      chk("pause_len", 32'(n), 32'(PAUSE_CYCLES));
    end
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    wb.ack = 1'b0;
    total  = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    chk("rst_stb", 32'(wb.stb), 32'd0);
    chk("rst_adr", wb.adr, 32'd0);
    chk("rst_dat", wb.dat_ms, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("we", 32'(wb.we), 32'd1);
    chk("sel", 32'(wb.sel), 32'hF);
    chk("cti", 32'(wb.cti), 32'd0);
    chk("bte", 32'(wb.bte), 32'd0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_enable", 32'(wb.cyc), 32'd0);

    // Enable: cyc must rise the cycle after enable is sampled
    enable = 1'b1;
    @(negedge clk);
    chk("enable_cyc", 32'(wb.cyc), 32'd1);

    // First tenure with 1-cycle acks, then pause and continuation
    for (int i = 0; i < BURST; i++) serve(1, 1'b0);

    // Randomized ack latency across two full frames and a bit more
    while (total < 2 * HDISP * VDISP + 30) serve(int'($urandom_range(1, 4)), 1'b0);

    // Drop enable while a word is waiting for its ack
    while (mwords != 0) serve(int'($urandom_range(1, 4)), 1'b0);
    serve(5, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_cyc", 32'(wb.cyc), 32'd1);
    for (int i = 0; i < 5; i++) serve(int'($urandom_range(1, 4)), 1'b0);

    // Reset in the middle of a write
    n = 0;
    while (wb.stb !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_stb", 32'(wb.stb), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cyc", 32'(wb.cyc), 32'd0);
    chk("midrst_stb", 32'(wb.stb), 32'd0);
    chk("midrst_adr", wb.adr, 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_rst_cyc", 32'(wb.cyc), 32'd1);
    for (int i = 0; i < 2 * BURST + 3; i++) serve(int'($urandom_range(1, 4)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
